traffic_phase_scheduler: RTL and testbench

Phase scheduler for the four-approach junction: main through (M1, M2), main turn (MT), side road (S), plus a pedestrian crossing.
- Latches turn, side and pedestrian requests.
- Holds main green for a minimum time, then serves pending requests round-robin, one service phase per main-green cycle.
- Sequences yellow and all-red clearance between phases.
- Emergency input pre-empts to main green.
- Drives the 3-bit lamp outputs directly.

---
 rtl/traffic_phase_scheduler.sv | 151 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Four-approach junction phase scheduler: main green hold, round-robin service of turn/side/ped,
// yellow + all-red clearance, emergency pre-emption. Optional PED_COUNTDOWN_EN adds ped_count.
module traffic_phase_scheduler #(
  parameter int TW         = 8,
  parameter int T_MAIN_MIN = 6,
  parameter int T_TURN     = 3,
  parameter int T_SIDE     = 4,
  parameter int T_PED      = 4,
  parameter int T_YEL      = 2,
  parameter int T_AR       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_turn,
  input  logic          req_side,
  input  logic          req_ped,
  input  logic          emerg,
  output logic [2:0]    light_M1,
  output logic [2:0]    light_M2,
  output logic [2:0]    light_MT,
  output logic [2:0]    light_S,
  output logic          walk,
  output logic [2:0]    pending
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [TW-1:0] ped_count
`endif
);

  localparam logic [3:0] S_MAIN_G = 4'd0, S_MAIN_Y = 4'd1, S_AR_IN  = 4'd2,
                         S_TURN_G = 4'd3, S_TURN_Y = 4'd4, S_SIDE_G = 4'd5,
                         S_SIDE_Y = 4'd6, S_PED_W  = 4'd7, S_PED_C  = 4'd8,
                         S_AR_OUT = 4'd9;

  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

  localparam logic [TW-1:0] L_MAIN = TW'(T_MAIN_MIN - 1);
  localparam logic [TW-1:0] L_TURN = TW'(T_TURN - 1);
  localparam logic [TW-1:0] L_SIDE = TW'(T_SIDE - 1);
  localparam logic [TW-1:0] L_PED  = TW'(T_PED - 1);
  localparam logic [TW-1:0] L_YEL  = TW'(T_YEL - 1);
  localparam logic [TW-1:0] L_AR   = TW'(T_AR - 1);

  logic [3:0]    r_state, w_nxt;
  logic [TW-1:0] r_timer, w_dur;
  logic [2:0]    r_pend, w_pend_nxt;
  logic [1:0]    r_ptr, r_sel, w_pick;
  logic          r_abort;
  logic          w_exp, w_enter_g;

  // phase index 0=turn, 1=side, 2=ped; offset k from pointer p, wrapped mod 3
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

  assign w_exp = (r_timer == '0);

  always_comb begin
    w_pick = 2'd0;
    for (int k = 2; k >= 0; k--)
      if (r_pend[rr_idx(r_ptr, k)]) w_pick = rr_idx(r_ptr, k);
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_MAIN_G: if (w_exp && (r_pend != 3'b000) && !emerg) w_nxt = S_MAIN_Y;
      S_MAIN_Y: if (w_exp) w_nxt = S_AR_IN;
      S_AR_IN:
        if (w_exp) begin
          if (r_abort)            w_nxt = S_MAIN_G;
          else if (r_sel == 2'd0) w_nxt = S_TURN_G;
          else if (r_sel == 2'd1) w_nxt = S_SIDE_G;
          else                    w_nxt = S_PED_W;
        end
      S_TURN_G: if (w_exp || emerg) w_nxt = S_TURN_Y;
      S_SIDE_G: if (w_exp || emerg) w_nxt = S_SIDE_Y;
      S_PED_W:  if (w_exp || emerg) w_nxt = S_PED_C;
      S_TURN_Y, S_SIDE_Y, S_PED_C: if (w_exp) w_nxt = S_AR_OUT;
      S_AR_OUT: if (w_exp) w_nxt = S_MAIN_G;
      default:  w_nxt = S_MAIN_G;
    endcase
  end

  always_comb begin
    case (w_nxt)
      S_MAIN_Y, S_TURN_Y, S_SIDE_Y, S_PED_C: w_dur = L_YEL;
      S_AR_IN, S_AR_OUT:                     w_dur = L_AR;
      S_TURN_G:                              w_dur = L_TURN;
      S_SIDE_G:                              w_dur = L_SIDE;
      S_PED_W:                               w_dur = L_PED;
      default:                               w_dur = L_MAIN;
    endcase
  end

  assign w_enter_g  = (r_state == S_AR_IN) && (w_nxt != S_AR_IN) && (w_nxt != S_MAIN_G);
  // the served phase's clear overrides a request arriving on the same edge
  assign w_pend_nxt = (r_pend | {req_ped, req_side, req_turn}) &
                      ~(w_enter_g ? (3'b001 << r_sel) : 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_MAIN_G;
      r_timer <= L_MAIN;
      r_pend  <= 3'b000;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) r_timer <= w_dur;
      else if (!w_exp)      r_timer <= r_timer - TW'(1);
      r_pend <= w_pend_nxt;
      if (r_state == S_MAIN_G && w_nxt == S_MAIN_Y) begin
        r_sel   <= w_pick;
        r_abort <= 1'b0;
      end else if (r_state == S_MAIN_Y && emerg) begin
        r_abort <= 1'b1;
      end
      if (w_enter_g) r_ptr <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
    end
  end

  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    walk     = 1'b0;
    case (r_state)
      S_MAIN_G: begin light_M1 = GRN; light_M2 = GRN; end
      S_MAIN_Y: begin light_M1 = YEL; light_M2 = YEL; end
      S_TURN_G: begin light_M1 = GRN; light_MT = GRN; end
      S_TURN_Y: begin light_M1 = YEL; light_MT = YEL; end
      S_SIDE_G: light_S = GRN;
      S_SIDE_Y: light_S = YEL;
      S_PED_W:  walk = 1'b1;
      default:  ;
    endcase
  end

  assign pending = r_pend;

`ifdef PED_COUNTDOWN_EN
  assign ped_count = (r_state == S_PED_W || r_state == S_PED_C) ? r_timer : '0;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: phase-level model checked every cycle, plus directed literal checks.
module tb_traffic_phase_scheduler;
  localparam int TW = 8, TMM = 6, TT = 3, TS = 4, TP = 4, TY = 2, TA = 1;
  localparam int K_MG = 0, K_MY = 1, K_ARI = 2, K_GRN = 3, K_CLR = 4, K_ARO = 5;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic clk = 1'b0, rst = 1'b1;
  logic req_turn = 1'b0, req_side = 1'b0, req_ped = 1'b0, emerg = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_S, pending;
  logic walk;
`ifdef PED_COUNTDOWN_EN
  logic [TW-1:0] ped_count;
`endif

  traffic_phase_scheduler #(.TW(TW), .T_MAIN_MIN(TMM), .T_TURN(TT), .T_SIDE(TS),
                            .T_PED(TP), .T_YEL(TY), .T_AR(TA)) dut (
    .clk(clk), .rst(rst), .req_turn(req_turn), .req_side(req_side), .req_ped(req_ped),
    .emerg(emerg), .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT),
    .light_S(light_S), .walk(walk), .pending(pending)
`ifdef PED_COUNTDOWN_EN
    , .ped_count(ped_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit live = 1'b0;

  // model: phase kind + served phase (0 turn, 1 side, 2 ped), cycles spent in the phase
  int m_kind = K_MG, m_age = 0, m_svc = 0, m_ptr = 0;
  bit m_abort = 1'b0;
  bit [2:0] m_pend = 3'b000;

  function automatic int dur(int kind, int svc);
    case (kind)
      K_MG:         return TMM;
      K_MY, K_CLR:  return TY;
      K_ARI, K_ARO: return TA;
      default:      return (svc == 0) ? TT : (svc == 1) ? TS : TP;
    endcase
  endfunction

  function automatic logic [12:0] exp_out(int kind, int svc);
    logic [2:0] m1, m2, mt, s;
    logic w;
    m1 = R; m2 = R; mt = R; s = R; w = 1'b0;
    if (kind == K_MG) begin m1 = G; m2 = G; end
    else if (kind == K_MY) begin m1 = Y; m2 = Y; end
    else if (kind == K_GRN) begin
      if (svc == 0) begin m1 = G; mt = G; end
      else if (svc == 1) s = G;
      else w = 1'b1;
    end else if (kind == K_CLR) begin
      if (svc == 0) begin m1 = Y; mt = Y; end
      else if (svc == 1) s = Y;
    end
    return {m1, m2, mt, s, w};
  endfunction

  always @(posedge clk) begin
    bit ex, nab, found;
    bit [2:0] np;
    int nk, na, ns, nptr, idx;
    if (rst) begin
      nk = K_MG; na = 0; ns = 0; nptr = 0; nab = 1'b0; np = 3'b000;
    end else begin
      ex = (m_age >= dur(m_kind, m_svc) - 1);
      np = m_pend | {req_ped, req_side, req_turn};
      nk = m_kind; na = m_age + 1; ns = m_svc; nptr = m_ptr; nab = m_abort;
      case (m_kind)
        K_MG:
          if (ex && m_pend != 3'b000 && !emerg) begin
            nk = K_MY; nab = 1'b0; found = 1'b0;
            for (int k = 0; k < 3; k++) begin
              idx = (m_ptr + k) % 3;
              if (!found && m_pend[idx]) begin ns = idx; found = 1'b1; end
            end
          end
        K_MY: begin
          if (emerg) nab = 1'b1;
          if (ex) nk = K_ARI;
        end
        K_ARI:
          if (ex) begin
            if (m_abort) nk = K_MG;
            else begin
              nk = K_GRN; np[m_svc] = 1'b0; nptr = (m_svc + 1) % 3;
            end
          end
        K_GRN: if (ex || emerg) nk = K_CLR;
        K_CLR: if (ex) nk = K_ARO;
        default: if (ex) nk = K_MG;
      endcase
      if (nk != m_kind) na = 0;
    end
    m_kind <= nk; m_age <= na; m_svc <= ns; m_ptr <= nptr; m_abort <= nab; m_pend <= np;
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (live) begin
      e = exp_out(m_kind, m_svc);
      n_tests++;
      if ({light_M1, light_M2, light_MT, light_S, walk} !== e) begin
        n_fail++;
        $display("FAIL model_lamps cyc=%0d got=%b want=%b", cyc,
                 {light_M1, light_M2, light_MT, light_S, walk}, e);
      end
      n_tests++;
      if (pending !== m_pend) begin
        n_fail++;
        $display("FAIL model_pending cyc=%0d got=%b want=%b", cyc, pending, m_pend);
      end
`ifdef PED_COUNTDOWN_EN
      n_tests++;
      if (ped_count !== TW'((m_kind == K_GRN && m_svc == 2) ? TP - 1 - m_age :
                            (m_kind == K_CLR && m_svc == 2) ? TY - 1 - m_age : 0)) begin
        n_fail++;
        $display("FAIL model_ped_count cyc=%0d got=%0d kind=%0d age=%0d", cyc, ped_count, m_kind, m_age);
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_turn = 1'b0; req_side = 1'b0; req_ped = 1'b0; emerg = 1'b0;
    tick(); live = 1'b1; tick();
    rst = 1'b0; cyc = 0;
  endtask

  initial begin
    // idle: main green forever
    do_reset();
    chk("rst_M1", light_M1, G); chk("rst_S", light_S, R); chk("rst_pend", pending, 0);
    run_to(50);
    chk("idle_M1", light_M1, G); chk("idle_M2", light_M2, G); chk("idle_MT", light_MT, R);
    chk("idle_walk", walk, 0); chk("idle_pend", pending, 0);

    // single side request
    do_reset();
    req_side = 1'b1; tick(); req_side = 1'b0;
    chk("side_pend1", pending, 3'b010);
    run_to(5);  chk("side_mg5", light_M1, G);
    run_to(6);  chk("side_my6", light_M1, Y);
    run_to(8);  chk("side_ar8", light_M1, R); chk("side_pend8", pending, 3'b010);
    run_to(9);  chk("side_g9", light_S, G); chk("side_pend9", pending, 0);
    run_to(12); chk("side_g12", light_S, G);
    run_to(13); chk("side_y13", light_S, Y);
    run_to(15); chk("side_ar15", light_S, R); chk("side_ar15m", light_M1, R);
    run_to(16); chk("side_mg16", light_M1, G);

    // all three: TURN, SIDE, PED in turn
    do_reset();
    req_turn = 1'b1; req_side = 1'b1; req_ped = 1'b1; tick();
    req_turn = 1'b0; req_side = 1'b0; req_ped = 1'b0;
    run_to(8);  chk("rr_pend8", pending, 3'b111);
    run_to(9);  chk("rr_turn9", light_MT, G); chk("rr_m1_9", light_M1, G); chk("rr_pend9", pending, 3'b110);
    run_to(12); chk("rr_turny12", light_MT, Y);
    run_to(15); chk("rr_mg15", light_M1, G);
    run_to(24); chk("rr_side24", light_S, G); chk("rr_pend24", pending, 3'b100);
    run_to(40); chk("rr_walk40", walk, 1); chk("rr_pend40", pending, 0);
`ifdef PED_COUNTDOWN_EN
    chk("rr_cnt40", ped_count, 3);
`endif
    run_to(44); chk("rr_pedc44", walk, 0);
`ifdef PED_COUNTDOWN_EN
    chk("rr_cnt44", ped_count, 1);
`endif
    run_to(47); chk("rr_mg47", light_M1, G);

    // emergency during side green, then holding main
    do_reset();
    req_side = 1'b1; tick(); req_side = 1'b0;
    run_to(10); chk("em_sg10", light_S, G); emerg = 1'b1;
    run_to(11); chk("em_sy11", light_S, Y);
    req_turn = 1'b1; tick(); req_turn = 1'b0;
    run_to(13); chk("em_ar13", light_S, R); chk("em_ar13m", light_M1, R);
    run_to(14); chk("em_mg14", light_M1, G);
    run_to(30); chk("em_hold30", light_M1, G); chk("em_pend30", pending, 3'b001);
    emerg = 1'b0;
    run_to(31); chk("em_rel31", light_M1, Y);
    run_to(50);

    // turn held high; side/ped still get their turn first
    do_reset();
    req_turn = 1'b1;
    run_to(9);  chk("hold_tg9", light_MT, G); chk("hold_pend9", pending, 0);
    run_to(10); chk("hold_pend10", pending, 3'b001);
    req_side = 1'b1; req_ped = 1'b1; tick(); req_side = 1'b0; req_ped = 1'b0;
    chk("hold_pend11", pending, 3'b111);
    run_to(24); chk("hold_side24", light_S, G); chk("hold_pend24", pending, 3'b101);
    run_to(40); chk("hold_walk40", walk, 1);
    run_to(56); chk("hold_turn56", light_MT, G);
    req_turn = 1'b0;
    run_to(70);

    // reset during walk
    do_reset();
    req_ped = 1'b1; tick(); req_ped = 1'b0;
    run_to(9); chk("rw_walk9", walk, 1);
`ifdef PED_COUNTDOWN_EN
    chk("rw_cnt9", ped_count, 3);
`endif
    req_ped = 1'b1; tick(); req_ped = 1'b0;
    chk("rw_pend10", pending, 3'b100);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rw_walk11", walk, 0); chk("rw_m1_11", light_M1, G); chk("rw_pend11", pending, 0);
`ifdef PED_COUNTDOWN_EN
    chk("rw_cnt11", ped_count, 0);
`endif
    req_side = 1'b1; tick(); req_side = 1'b0;
    chk("rw_pend12", pending, 3'b010);
    run_to(16); chk("rw_mg16", light_M1, G);
    run_to(17); chk("rw_my17", light_M1, Y);

    // random traffic with emergency bursts, model-checked
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req_turn = ($urandom_range(0, 9) == 0);
      req_side = ($urandom_range(0, 9) == 0);
      req_ped  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 29) == 0) emerg = ~emerg;
      tick();
    end
    emerg = 1'b0; req_turn = 1'b0; req_side = 1'b0; req_ped = 1'b0;
    run_to(540);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
